// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helpers for the serial BCD adder.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] digit);
    return BCD_MAX - digit;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder cell: binary add followed by the +6 decimal correction.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s_d,
  output logic               cout
);

  logic [DIGIT_W:0]   raw;
  logic [DIGIT_W-1:0] adj;

  always_comb begin
    raw = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, cin};
    adj = raw[DIGIT_W-1:0] + 4'd6;
    if (raw > {1'b0, BCD_MAX}) begin
      s_d  = adj;
      cout = 1'b1;
    end else begin
      s_d  = raw[DIGIT_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder/subtractor, one digit per clock LSD first, valid/ready on both sides.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      cin,
  input  logic                      sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                      cout,
  output logic                      err
);

  localparam int unsigned W    = DIGIT_W * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > BCD_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            bad_q, bad_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
  logic               dig_c;

  assign dig_a = a_q[idx_q*DIGIT_W +: DIGIT_W];
  assign dig_b = b_q[idx_q*DIGIT_W +: DIGIT_W];

  bcd_digit_adder u_digit (
    .a_d  (dig_a),
    .b_d  (dig_b),
    .cin  (carry_q),
    .s_d  (dig_s),
    .cout (dig_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    bad_d   = bad_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d = a;
          // Subtraction adds the 9's complement of b plus a forced carry-in.
          for (int i = 0; i < int'(DIGITS); i++) begin
            b_d[i*DIGIT_W +: DIGIT_W] = sub ? nines_comp(b[i*DIGIT_W +: DIGIT_W])
                                            : b[i*DIGIT_W +: DIGIT_W];
          end
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          bad_d   = has_bad_digit(a) | has_bad_digit(b);
          acc_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d[idx_q*DIGIT_W +: DIGIT_W] = dig_s;
        carry_d = dig_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          sum_d   = bad_q ? '0 : acc_d;
          cout_d  = bad_q ? 1'b0 : dig_c;
          err_d   = bad_q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed and random checks of bcd_serial_adder against an integer-arithmetic reference model.
module tb_bcd_serial_adder;

  localparam int D   = 4;
  localparam int W   = 4 * D;
  localparam int MOD = 10 ** D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_err;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [W-1:0] v);
    int n = 0;
    for (int i = D - 1; i >= 0; i--) n = n * 10 + int'(v[i*4 +: 4]);
    return n;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int m = n;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic bad_digits(input logic [W-1:0] v);
    logic [W-1:0] t = v;
    for (int i = 0; i < D; i++) if (t[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       input logic ms);
    int av, bv, t;
    av = bcd2int(ma);
    bv = bcd2int(mb);
    if (bad_digits(ma) || bad_digits(mb)) begin
      exp_sum = '0; exp_cout = 1'b0; exp_err = 1'b1;
    end else if (ms) begin
      t = av - bv;
      exp_cout = (t >= 0);
      exp_sum  = int2bcd((t + MOD) % MOD);
      exp_err  = 1'b0;
    end else begin
      t = av + bv + int'(mc);
      exp_cout = (t >= MOD);
      exp_sum  = int2bcd(t % MOD);
      exp_err  = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Ends at the negedge just after the accept edge.
  task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          input logic os);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = oa; b = ob; cin = oc; sub = os; in_valid = 1'b1;
    model(oa, ob, oc, os);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(D));
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_after_take"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after_take"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic oc, input logic os);
    start_op(oa, ob, oc, os);
    wait_done(tag);
    take(tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    // Reset
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0);
    run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0);
    run_op("add_0999_cin", 16'h0999, 16'h0000, 1'b1, 1'b0);
    run_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b0, 1'b1);
    run_op("sub_1234_5000", 16'h1234, 16'h5000, 1'b1, 1'b1);
    run_op("sub_0000_0000", 16'h0000, 16'h0000, 1'b0, 1'b1);
    run_op("err_12a4", 16'h12A4, 16'h0001, 1'b0, 1'b0);
    run_op("after_err", 16'h0042, 16'h0017, 1'b0, 1'b0);

    // Backpressure: result held, new requests ignored.
    start_op(16'h4321, 16'h1111, 1'b0, 1'b0);
    wait_done("bp");
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 1);
      a = 16'h9999; b = 16'h9999;
      @(negedge clk);
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'(exp_sum));
      check("bp_hold_cout", 32'(cout), 32'(exp_cout));
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    take("bp");

    // Reset in the middle of a run.
    start_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    run_op("post_rst_0005_0005", 16'h0005, 16'h0005, 1'b0, 1'b0);

    // Random operations, with an occasional invalid digit.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < D; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, D - 1)*4 +: 4] = 4'($urandom_range(10, 15));
      run_op("random", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
